// File: rtl/reg_file_mp_if.sv
// -----------------------------------------------------------------------------
// reg_file_mp_if
//   Bundles the issue/writeback side signals of the multi-port register file.
//   The register file has no valid/ready handshake: every input is acted on
//   in the cycle it is presented. Reads are combinational. Writes, scoreboard
//   sets and the conflict flag take effect at the next rising clock edge.
//
//   master : core side (decode/issue/writeback) drives the requests and
//            observes the read data and scoreboard state.
//   slave  : register file side.
//
//   Signals
//     wr_en        per-port write enable              (NUM_WR)
//     wr_addr      packed write indices               (NUM_WR*ADDR_WIDTH)
//     wr_data      packed write data                  (NUM_WR*DATA_WIDTH)
//     rd_addr      packed read indices                (NUM_RD*ADDR_WIDTH)
//     rd_data      packed read data                   (NUM_RD*DATA_WIDTH)
//     rd_busy      read port targets a busy register  (NUM_RD)
//     sb_set_en    mark sb_set_addr busy              (1)
//     sb_set_addr  register to mark busy              (ADDR_WIDTH)
//     busy         registered scoreboard vector       (2**ADDR_WIDTH)
//     wr_conflict  previous cycle had a write clash   (1)
// -----------------------------------------------------------------------------
interface reg_file_mp_if #(
   parameter int ADDR_WIDTH = 5,
   parameter int DATA_WIDTH = 32,
   parameter int NUM_RD     = 2,
   parameter int NUM_WR     = 2
);
   logic [NUM_WR-1:0]             wr_en;
   logic [NUM_WR*ADDR_WIDTH-1:0]  wr_addr;
   logic [NUM_WR*DATA_WIDTH-1:0]  wr_data;
   logic [NUM_RD*ADDR_WIDTH-1:0]  rd_addr;
   logic [NUM_RD*DATA_WIDTH-1:0]  rd_data;
   logic [NUM_RD-1:0]             rd_busy;
   logic                          sb_set_en;
   logic [ADDR_WIDTH-1:0]         sb_set_addr;
   logic [(2**ADDR_WIDTH)-1:0]    busy;
   logic                          wr_conflict;

   modport master (
      output wr_en, wr_addr, wr_data, rd_addr, sb_set_en, sb_set_addr,
      input  rd_data, rd_busy, busy, wr_conflict
   );

   modport slave (
      input  wr_en, wr_addr, wr_data, rd_addr, sb_set_en, sb_set_addr,
      output rd_data, rd_busy, busy, wr_conflict
   );
endinterface

// File: rtl/reg_file_mp.sv
// -----------------------------------------------------------------------------
// reg_file_mp
//   Multi-port integer register file with optional write-to-read bypass and
//   a per-register busy scoreboard for hazard detection.
//
//   Ports
//     clk  : clock, all state changes on the rising edge
//     rst  : synchronous active-high reset (clears registers, busy, conflict)
//     bus  : reg_file_mp_if.slave -- write ports, read ports, scoreboard set,
//            busy vector and write-conflict flag
//
//   Register 0 is hard-wired to zero: writes to it are dropped, it never
//   becomes busy and it never contributes to a write conflict.
// -----------------------------------------------------------------------------
module reg_file_mp #(
   parameter int ADDR_WIDTH = 5,
   parameter int DATA_WIDTH = 32,
   parameter int NUM_RD     = 2,
   parameter int NUM_WR     = 2,
   parameter int BYPASS     = 1
) (
   input  logic          clk,
   input  logic          rst,
   reg_file_mp_if.slave  bus
);
   localparam int DEPTH = 2**ADDR_WIDTH;

   logic [DATA_WIDTH-1:0] regs_q [DEPTH];
   logic [DATA_WIDTH-1:0] regs_d [DEPTH];
   logic [DEPTH-1:0]      busy_q, busy_d;
   logic                  conflict_q, conflict_d;

   // Unpacked views of the packed port buses
   logic [ADDR_WIDTH-1:0] waddr [NUM_WR];
   logic [DATA_WIDTH-1:0] wdata [NUM_WR];
   logic [NUM_WR-1:0]     wen_nz;       // enabled write to a non-zero register
   logic [ADDR_WIDTH-1:0] raddr [NUM_RD];
   logic [DATA_WIDTH-1:0] rdv   [NUM_RD];

   logic [DEPTH-1:0]      clr, set;
   logic [NUM_RD*DATA_WIDTH-1:0] rd_data;
   logic [NUM_RD-1:0]            rd_busy;

   always_comb begin : unpack
      for (int k = 0; k < NUM_WR; k++) begin
         waddr[k]  = bus.wr_addr[k*ADDR_WIDTH +: ADDR_WIDTH];
         wdata[k]  = bus.wr_data[k*DATA_WIDTH +: DATA_WIDTH];
         wen_nz[k] = bus.wr_en[k] && (waddr[k] != '0);
      end
      for (int i = 0; i < NUM_RD; i++) begin
         raddr[i] = bus.rd_addr[i*ADDR_WIDTH +: ADDR_WIDTH];
      end
   end

   // Next-state for the array, scoreboard and conflict flag.
   // Ports are applied in ascending order so the highest index wins a clash.
   always_comb begin : next_state
      regs_d     = regs_q;
      clr        = '0;
      set        = '0;
      conflict_d = 1'b0;
      for (int k = 0; k < NUM_WR; k++) begin
         if (wen_nz[k]) begin
            regs_d[waddr[k]] = wdata[k];
            clr[waddr[k]]    = 1'b1;
         end
      end
      if (bus.sb_set_en && (bus.sb_set_addr != '0)) begin
         set[bus.sb_set_addr] = 1'b1;
      end
      // A set in the same cycle as a clear wins: a new producer was issued.
      busy_d    = (busy_q & ~clr) | set;
      busy_d[0] = 1'b0;
      for (int j = 0; j < NUM_WR; j++) begin
         for (int k = j + 1; k < NUM_WR; k++) begin
            if (wen_nz[j] && wen_nz[k] && (waddr[j] == waddr[k])) begin
               conflict_d = 1'b1;
            end
         end
      end
   end

   // Combinational read ports
   always_comb begin : read_ports
      rd_data = '0;
      rd_busy = '0;
      for (int i = 0; i < NUM_RD; i++) begin
         rdv[i] = regs_q[raddr[i]];
         if (BYPASS != 0) begin
            for (int k = 0; k < NUM_WR; k++) begin
               if (wen_nz[k] && (waddr[k] == raddr[i])) begin
                  rdv[i] = wdata[k];
               end
            end
         end
         if (raddr[i] == '0) begin
            rdv[i] = '0;
         end
         rd_data[i*DATA_WIDTH +: DATA_WIDTH] = rdv[i];

         // With bypass, a writeback in this cycle already satisfies the hazard.
         if (BYPASS != 0) begin
            rd_busy[i] = busy_q[raddr[i]] & ~clr[raddr[i]];
         end else begin
            rd_busy[i] = busy_q[raddr[i]];
         end
         if (raddr[i] == '0) begin
            rd_busy[i] = 1'b0;
         end
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         for (int a = 0; a < DEPTH; a++) begin
            regs_q[a] <= '0;
         end
         busy_q     <= '0;
         conflict_q <= 1'b0;
      end else begin
         regs_q     <= regs_d;
         busy_q     <= busy_d;
         conflict_q <= conflict_d;
      end
   end

   assign bus.rd_data     = rd_data;
   assign bus.rd_busy     = rd_busy;
   assign bus.busy        = busy_q;
   assign bus.wr_conflict = conflict_q;

endmodule

// File: tb/tb_reg_file_mp.sv
// -----------------------------------------------------------------------------
// tb_reg_file_mp
//   Drives identical stimulus into a BYPASS=1 and a BYPASS=0 instance of
//   reg_file_mp. Expected read data is pushed to exp_q when the stimulus is
//   applied and popped when the outputs are sampled, in the order
//   [bypass port0, bypass port1, no-bypass port0, no-bypass port1].
// -----------------------------------------------------------------------------
module tb_reg_file_mp;
   localparam int AW = 5;
   localparam int DW = 32;
   localparam int NR = 2;
   localparam int NW = 2;
   localparam int DEPTH = 32;

   // ---------------- clock / reset ----------------
   logic clk = 1'b0;
   logic rst;
   always #5 clk = ~clk;

   logic [NW-1:0]    wr_en;
   logic [NW*AW-1:0] wr_addr;
   logic [NW*DW-1:0] wr_data;
   logic [NR*AW-1:0] rd_addr;
   logic             sb_set_en;
   logic [AW-1:0]    sb_set_addr;

   reg_file_mp_if #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .NUM_RD(NR), .NUM_WR(NW)) bus_b ();
   reg_file_mp_if #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .NUM_RD(NR), .NUM_WR(NW)) bus_n ();

   assign bus_b.wr_en = wr_en;           assign bus_n.wr_en = wr_en;
   assign bus_b.wr_addr = wr_addr;       assign bus_n.wr_addr = wr_addr;
   assign bus_b.wr_data = wr_data;       assign bus_n.wr_data = wr_data;
   assign bus_b.rd_addr = rd_addr;       assign bus_n.rd_addr = rd_addr;
   assign bus_b.sb_set_en = sb_set_en;   assign bus_n.sb_set_en = sb_set_en;
   assign bus_b.sb_set_addr = sb_set_addr; assign bus_n.sb_set_addr = sb_set_addr;

   reg_file_mp #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .NUM_RD(NR), .NUM_WR(NW), .BYPASS(1))
      dut_b (.clk(clk), .rst(rst), .bus(bus_b));
   reg_file_mp #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .NUM_RD(NR), .NUM_WR(NW), .BYPASS(0))
      dut_n (.clk(clk), .rst(rst), .bus(bus_n));

   // ---------------- scoreboard / model ----------------
   logic [DW-1:0]    exp_q [$];
   logic [DW-1:0]    m_regs [DEPTH];
   logic [DEPTH-1:0] m_busy;
   logic             m_conf;
   int checks = 0;
   int errors = 0;

   function automatic logic [AW-1:0] wa(int k);
      return wr_addr[k*AW +: AW];
   endfunction

   function automatic logic [DW-1:0] model_rd(bit bypass, logic [AW-1:0] a);
      logic [DW-1:0] v;
      if (a == 0) return '0;
      v = m_regs[a];
      if (bypass)
         for (int k = 0; k < NW; k++)
            if (wr_en[k] && wa(k) == a) v = wr_data[k*DW +: DW];
      return v;
   endfunction

   function automatic bit model_clr(logic [AW-1:0] a);
      for (int k = 0; k < NW; k++)
         if (wr_en[k] && wa(k) == a && a != 0) return 1'b1;
      return 1'b0;
   endfunction

   function automatic logic [DW-1:0] rd_out(int slot);
      if (slot < 2) return bus_b.rd_data[slot*DW +: DW];
      return bus_n.rd_data[(slot-2)*DW +: DW];
   endfunction

   // ---------------- driver tasks ----------------
   task automatic idle();
      wr_en = '0; wr_addr = '0; wr_data = '0;
      sb_set_en = 1'b0; sb_set_addr = '0; rst = 1'b0;
   endtask

   task automatic push_reads();
      for (int d = 0; d < 2; d++)
         for (int p = 0; p < NR; p++)
            exp_q.push_back(model_rd(d == 0, rd_addr[p*AW +: AW]));
   endtask

   // Advance the model with the current inputs, then clock the DUTs.
   task automatic step();
      logic [DEPTH-1:0] cl;
      if (rst) begin
         for (int a = 0; a < DEPTH; a++) m_regs[a] = '0;
         m_busy = '0;
         m_conf = 1'b0;
      end else begin
         cl = '0;
         for (int k = 0; k < NW; k++)
            if (wr_en[k] && wa(k) != 0) begin
               m_regs[wa(k)] = wr_data[k*DW +: DW];
               cl[wa(k)] = 1'b1;
            end
         m_busy = m_busy & ~cl;
         if (sb_set_en && sb_set_addr != 0) m_busy[sb_set_addr] = 1'b1;
         m_conf = (wr_en == 2'b11) && (wa(0) == wa(1)) && (wa(0) != 0);
      end
      @(posedge clk);
      #1;
   endtask

   // ---------------- tests ----------------
   task automatic test_reset();
      logic [DW-1:0] e, g;
      idle();
      for (int a = 0; a < DEPTH; a++) m_regs[a] = 'x;
      m_busy = 'x;
      for (int c = 0; c < 16; c++) begin
         wr_en = 2'b11;
         wr_addr = {5'(2*c+1), 5'(2*c)};
         wr_data = {$urandom(), $urandom()};
         sb_set_en = 1'b1; sb_set_addr = 5'(c + 1);
         step();
      end
      idle();
      rst = 1'b1;
      step();
      rst = 1'b0;
      checks++;
      if (bus_b.busy !== '0 || bus_n.busy !== '0) begin
         errors++; $display("FAIL reset_busy got %h/%h exp 0", bus_b.busy, bus_n.busy);
      end
      checks++;
      if (bus_b.wr_conflict !== 1'b0 || bus_n.wr_conflict !== 1'b0) begin
         errors++; $display("FAIL reset_conflict got %b/%b exp 0", bus_b.wr_conflict, bus_n.wr_conflict);
      end
      for (int c = 0; c < 16; c++) begin
         rd_addr = {5'(2*c+1), 5'(2*c)};
         for (int s = 0; s < 4; s++) exp_q.push_back('0);
         #1;
         for (int s = 0; s < 4; s++) begin
            e = exp_q.pop_front(); g = rd_out(s); checks++;
            if (g !== e) begin
               errors++; $display("FAIL reset_read addr%0d slot%0d got %h exp %h", 2*c+s%2, s, g, e);
            end
         end
         checks++;
         if (bus_b.rd_busy !== 2'b00 || bus_n.rd_busy !== 2'b00) begin
            errors++; $display("FAIL reset_rd_busy got %b/%b exp 00", bus_b.rd_busy, bus_n.rd_busy);
         end
      end
   endtask

   task automatic test_write_read();
      logic [DW-1:0] e, g;
      idle();
      wr_en = 2'b01; wr_addr = {5'd0, 5'd5}; wr_data = {32'h0, 32'hDEADBEEF};
      step();
      idle();
      rd_addr = {5'd5, 5'd5};
      for (int s = 0; s < 4; s++) exp_q.push_back(32'hDEADBEEF);
      #1;
      for (int s = 0; s < 4; s++) begin
         e = exp_q.pop_front(); g = rd_out(s); checks++;
         if (g !== e) begin errors++; $display("FAIL write_reg5 slot%0d got %h exp %h", s, g, e); end
      end
      wr_en = 2'b01; wr_addr = {5'd0, 5'd0}; wr_data = {32'h0, 32'h1234};
      step();
      idle();
      rd_addr = {5'd0, 5'd0};
      for (int s = 0; s < 4; s++) exp_q.push_back('0);
      #1;
      for (int s = 0; s < 4; s++) begin
         e = exp_q.pop_front(); g = rd_out(s); checks++;
         if (g !== e) begin errors++; $display("FAIL write_reg0 slot%0d got %h exp %h", s, g, e); end
      end
   endtask

   task automatic test_bypass();
      logic [DW-1:0] e, g;
      idle();
      wr_en = 2'b10; wr_addr = {5'd7, 5'd0}; wr_data = {32'hA5A5A5A5, 32'h0};
      rd_addr = {5'd5, 5'd7};
      exp_q.push_back(32'hA5A5A5A5); exp_q.push_back(32'hDEADBEEF);
      exp_q.push_back(32'h0);        exp_q.push_back(32'hDEADBEEF);
      #1;
      for (int s = 0; s < 4; s++) begin
         e = exp_q.pop_front(); g = rd_out(s); checks++;
         if (g !== e) begin errors++; $display("FAIL bypass_same_cycle slot%0d got %h exp %h", s, g, e); end
      end
      step();
      idle();
      exp_q.push_back(32'hA5A5A5A5); exp_q.push_back(32'hDEADBEEF);
      exp_q.push_back(32'hA5A5A5A5); exp_q.push_back(32'hDEADBEEF);
      #1;
      for (int s = 0; s < 4; s++) begin
         e = exp_q.pop_front(); g = rd_out(s); checks++;
         if (g !== e) begin errors++; $display("FAIL bypass_next_cycle slot%0d got %h exp %h", s, g, e); end
      end
   endtask

   task automatic test_conflict();
      logic [DW-1:0] e, g;
      idle();
      wr_en = 2'b11; wr_addr = {5'd9, 5'd9}; wr_data = {32'h22, 32'h11};
      rd_addr = {5'd9, 5'd9};
      exp_q.push_back(32'h22); exp_q.push_back(32'h22);
      exp_q.push_back(32'h0);  exp_q.push_back(32'h0);
      #1;
      for (int s = 0; s < 4; s++) begin
         e = exp_q.pop_front(); g = rd_out(s); checks++;
         if (g !== e) begin errors++; $display("FAIL conflict_bypass slot%0d got %h exp %h", s, g, e); end
      end
      step();
      idle();
      checks++;
      if (bus_b.wr_conflict !== 1'b1 || bus_n.wr_conflict !== 1'b1) begin
         errors++; $display("FAIL conflict_pulse got %b/%b exp 1", bus_b.wr_conflict, bus_n.wr_conflict);
      end
      for (int s = 0; s < 4; s++) exp_q.push_back(32'h22);
      #1;
      for (int s = 0; s < 4; s++) begin
         e = exp_q.pop_front(); g = rd_out(s); checks++;
         if (g !== e) begin errors++; $display("FAIL conflict_winner slot%0d got %h exp %h", s, g, e); end
      end
      step();
      checks++;
      if (bus_b.wr_conflict !== 1'b0 || bus_n.wr_conflict !== 1'b0) begin
         errors++; $display("FAIL conflict_clear got %b/%b exp 0", bus_b.wr_conflict, bus_n.wr_conflict);
      end
      wr_en = 2'b11; wr_addr = {5'd0, 5'd0}; wr_data = {32'h33, 32'h44};
      step();
      idle();
      checks++;
      if (bus_b.wr_conflict !== 1'b0 || bus_n.wr_conflict !== 1'b0) begin
         errors++; $display("FAIL conflict_reg0 got %b/%b exp 0", bus_b.wr_conflict, bus_n.wr_conflict);
      end
      wr_en = 2'b11; wr_addr = {5'd13, 5'd12}; wr_data = {32'h13, 32'h12};
      step();
      idle();
      checks++;
      if (bus_b.wr_conflict !== 1'b0 || bus_n.wr_conflict !== 1'b0) begin
         errors++; $display("FAIL conflict_distinct got %b/%b exp 0", bus_b.wr_conflict, bus_n.wr_conflict);
      end
   endtask

   task automatic test_scoreboard();
      logic [DW-1:0] e, g;
      idle();
      sb_set_en = 1'b1; sb_set_addr = 5'd3;
      step();
      idle();
      rd_addr = {5'd0, 5'd3};
      #1;
      checks++;
      if (bus_b.busy[3] !== 1'b1 || bus_n.busy[3] !== 1'b1) begin
         errors++; $display("FAIL sb_set_busy got %b/%b exp 1", bus_b.busy[3], bus_n.busy[3]);
      end
      checks++;
      if (bus_b.rd_busy !== 2'b01 || bus_n.rd_busy !== 2'b01) begin
         errors++; $display("FAIL sb_rd_busy got %b/%b exp 01", bus_b.rd_busy, bus_n.rd_busy);
      end
      wr_en = 2'b01; wr_addr = {5'd0, 5'd3}; wr_data = {32'h0, 32'h3333};
      exp_q.push_back(32'h3333); exp_q.push_back(32'h0);
      exp_q.push_back(32'h0);    exp_q.push_back(32'h0);
      #1;
      for (int s = 0; s < 4; s++) begin
         e = exp_q.pop_front(); g = rd_out(s); checks++;
         if (g !== e) begin errors++; $display("FAIL sb_wb_data slot%0d got %h exp %h", s, g, e); end
      end
      checks++;
      if (bus_b.rd_busy !== 2'b00 || bus_n.rd_busy !== 2'b01) begin
         errors++; $display("FAIL sb_wb_rd_busy got %b/%b exp 00/01", bus_b.rd_busy, bus_n.rd_busy);
      end
      step();
      idle();
      checks++;
      if (bus_b.busy[3] !== 1'b0 || bus_n.busy[3] !== 1'b0) begin
         errors++; $display("FAIL sb_cleared got %b/%b exp 0", bus_b.busy[3], bus_n.busy[3]);
      end
      sb_set_en = 1'b1; sb_set_addr = 5'd3;
      step();
      wr_en = 2'b10; wr_addr = {5'd3, 5'd0}; wr_data = {32'h4444, 32'h0};
      step();
      idle();
      checks++;
      if (bus_b.busy[3] !== 1'b1 || bus_n.busy[3] !== 1'b1) begin
         errors++; $display("FAIL sb_set_wins got %b/%b exp 1", bus_b.busy[3], bus_n.busy[3]);
      end
      sb_set_en = 1'b1; sb_set_addr = 5'd0;
      wr_en = 2'b01; wr_addr = {5'd0, 5'd3}; wr_data = {32'h0, 32'h5555};
      step();
      idle();
      checks++;
      if (bus_b.busy !== '0 || bus_n.busy !== '0) begin
         errors++; $display("FAIL sb_reg0_ignored got %h/%h exp 0", bus_b.busy, bus_n.busy);
      end
   endtask

   task automatic test_reset_during_write();
      logic [DW-1:0] e, g;
      idle();
      wr_en = 2'b11; wr_addr = {5'd11, 5'd10}; wr_data = {32'hBBBB, 32'hAAAA};
      sb_set_en = 1'b1; sb_set_addr = 5'd12;
      rst = 1'b1;
      step();
      idle();
      checks++;
      if (bus_b.busy !== '0 || bus_n.busy !== '0) begin
         errors++; $display("FAIL rst_write_busy got %h/%h exp 0", bus_b.busy, bus_n.busy);
      end
      rd_addr = {5'd11, 5'd10};
      for (int s = 0; s < 4; s++) exp_q.push_back('0);
      #1;
      for (int s = 0; s < 4; s++) begin
         e = exp_q.pop_front(); g = rd_out(s); checks++;
         if (g !== e) begin errors++; $display("FAIL rst_write_data slot%0d got %h exp %h", s, g, e); end
      end
      rd_addr = {5'd9, 5'd5};
      for (int s = 0; s < 4; s++) exp_q.push_back('0);
      #1;
      for (int s = 0; s < 4; s++) begin
         e = exp_q.pop_front(); g = rd_out(s); checks++;
         if (g !== e) begin errors++; $display("FAIL rst_old_data slot%0d got %h exp %h", s, g, e); end
      end
   endtask

   task automatic test_back_to_back();
      logic [DW-1:0] e, g;
      logic [NR-1:0] exp_rb_b, exp_rb_n;
      logic [AW-1:0] a;
      idle();
      step();
      for (int c = 0; c < 300; c++) begin
         wr_en = 2'($urandom_range(0, 3));
         wr_addr = {5'($urandom_range(0, 7)), 5'($urandom_range(0, 7))};
         wr_data = {$urandom(), $urandom()};
         sb_set_en = 1'($urandom_range(0, 1));
         sb_set_addr = 5'($urandom_range(0, 7));
         rd_addr = {5'($urandom_range(0, 7)), 5'($urandom_range(0, 7))};
         push_reads();
         for (int p = 0; p < NR; p++) begin
            a = rd_addr[p*AW +: AW];
            exp_rb_n[p] = (a != 0) && m_busy[a];
            exp_rb_b[p] = exp_rb_n[p] && !model_clr(a);
         end
         #1;
         for (int s = 0; s < 4; s++) begin
            e = exp_q.pop_front(); g = rd_out(s); checks++;
            if (g !== e) begin errors++; $display("FAIL b2b_read cyc%0d slot%0d got %h exp %h", c, s, g, e); end
         end
         checks++;
         if (bus_b.rd_busy !== exp_rb_b || bus_n.rd_busy !== exp_rb_n) begin
            errors++; $display("FAIL b2b_rd_busy cyc%0d got %b/%b exp %b/%b", c, bus_b.rd_busy, bus_n.rd_busy, exp_rb_b, exp_rb_n);
         end
         checks++;
         if (bus_b.busy !== m_busy || bus_n.busy !== m_busy) begin
            errors++; $display("FAIL b2b_busy cyc%0d got %h/%h exp %h", c, bus_b.busy, bus_n.busy, m_busy);
         end
         checks++;
         if (bus_b.wr_conflict !== m_conf || bus_n.wr_conflict !== m_conf) begin
            errors++; $display("FAIL b2b_conflict cyc%0d got %b/%b exp %b", c, bus_b.wr_conflict, bus_n.wr_conflict, m_conf);
         end
         step();
      end
      idle();
   endtask

   // ---------------- sequence and report ----------------
   initial begin
      idle();
      rd_addr = '0;
      m_conf = 1'b0;
      @(posedge clk);
      #1;
      test_reset();
      test_write_read();
      test_bypass();
      test_conflict();
      test_scoreboard();
      test_reset_during_write();
      test_back_to_back();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

   initial begin
      #2000000;
      $display("FAIL timeout got running exp finished");
      $fatal(1, "timeout");
   end

endmodule
